// File: rtl/alu4_issue_ctrl.sv
// Issue/writeback control stage for the 4-bit combinational ALU: one instruction
// in flight, 4x4 register file, result returned over a valid/ready handshake.
module alu4_issue_ctrl #(
    parameter int          CNT_W  = 8,
    parameter logic [3:0]  LDI_OP = 4'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_instr,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [4:0]       alu_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_err,
    output logic [1:0]       res_rd,
    input  logic [1:0]       dbg_sel,
    output logic [3:0]       dbg_data,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]       OP_ADD  = 4'd3;
    localparam logic [3:0]       OP_SUB  = 4'd4;
    localparam logic [3:0]       OP_XNOR = 4'd10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload stay stable until that edge.

    logic [1:0]       r_state;
    logic [3:0]       r_regs [4];
    logic [3:0]       r_op;
    logic [1:0]       r_rd;
    logic [3:0]       r_imm;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_res_valid;
    logic [3:0]       r_res_data;
    logic             r_res_carry;
    logic             r_res_zero;
    logic             r_res_err;
    logic [1:0]       r_res_rd;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_in_op;
    logic       w_in_is_alu;
    logic       w_accept;
    logic       w_is_ldi;
    logic       w_is_alu;
    logic       w_is_arith;
    logic       w_err;
    logic [3:0] w_exec_data;
    logic       w_exec_carry;

    assign w_in_op     = in_instr[11:8];
    assign w_in_is_alu = (w_in_op >= OP_ADD) && (w_in_op <= OP_XNOR) && (w_in_op != LDI_OP);
    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;

    assign w_is_ldi   = (r_op == LDI_OP);
    assign w_is_alu   = (r_op >= OP_ADD) && (r_op <= OP_XNOR) && !w_is_ldi;
    assign w_is_arith = w_is_alu && ((r_op == OP_ADD) || (r_op == OP_SUB));
    assign w_err      = !(w_is_ldi || w_is_alu);

    // Logic ops drop alu_res[4]: the ALU inverts over 5 bits, so it is not a flag.
    always_comb begin
        w_exec_data  = 4'd0;
        w_exec_carry = 1'b0;
        if (w_is_ldi) begin
            w_exec_data = r_imm;
        end else if (w_is_alu) begin
            w_exec_data  = alu_res[3:0];
            w_exec_carry = w_is_arith & alu_res[4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < 4; i++) r_regs[i] <= 4'd0;
            r_op        <= 4'd0;
            r_rd        <= 2'd0;
            r_imm       <= 4'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_op    <= 4'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'd0;
            r_res_carry <= 1'b0;
            r_res_zero  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_rd    <= 2'd0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_in_op;
                        r_rd  <= in_instr[7:6];
                        r_imm <= in_instr[3:0];
                        if (w_in_is_alu) begin
                            r_alu_a  <= r_regs[in_instr[5:4]];
                            r_alu_b  <= r_regs[in_instr[3:2]];
                            r_alu_op <= w_in_op;
                        end else begin
                            r_alu_op <= 4'd0;
                        end
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= w_exec_data;
                    r_res_carry <= w_exec_carry;
                    r_res_zero  <= (w_exec_data == 4'd0);
                    r_res_err   <= w_err;
                    r_res_rd    <= r_rd;
                    r_alu_op    <= 4'd0;
                    // Writeback here means the next accepted instruction sees the new value.
                    if (!w_err) begin
                        r_regs[r_rd] <= w_exec_data;
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_carry   = r_res_carry;
    assign res_zero    = r_res_zero;
    assign res_err     = r_res_err;
    assign res_rd      = r_res_rd;
    assign dbg_data    = r_regs[dbg_sel];
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// Directed bench for alu4_issue_ctrl with a behavioural 4-bit ALU on the
// alu_a/alu_b/alu_op -> alu_res path.
module tb_alu4_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_instr;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_res;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic        res_carry;
    logic        res_zero;
    logic        res_err;
    logic [1:0]  res_rd;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;
    logic [7:0]  retired_cnt;

    int errors = 0;
    int checks = 0;

    alu4_issue_ctrl #(.CNT_W(8), .LDI_OP(4'd1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err), .res_rd(res_rd),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 5'd0;
        case (alu_op)
            4'd3:  alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            4'd4:  alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            4'd5:  alu_res = {1'b0, alu_a & alu_b};
            4'd6:  alu_res = ~{1'b0, alu_a & alu_b};
            4'd7:  alu_res = {1'b0, alu_a | alu_b};
            4'd8:  alu_res = ~{1'b0, alu_a | alu_b};
            4'd9:  alu_res = {1'b0, alu_a ^ alu_b};
            4'd10: alu_res = ~{1'b0, alu_a ^ alu_b};
            default: alu_res = 5'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction, wait for acceptance, and step into RESP.
    task automatic issue(input logic [11:0] instr);
        int n;
        n = 0;
        in_instr = instr;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("exec_in_ready", in_ready, 0);
        tick();
        chk("resp_valid", res_valid, 1);
    endtask

    task automatic release_resp();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("resp_drop", res_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    task automatic ldi(input logic [1:0] rd, input logic [3:0] imm);
        issue({4'd1, rd, 2'b00, imm});
        chk("ldi_data", res_data, imm);
        release_resp();
    endtask

    function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    task automatic check_res(input string tag, input logic [3:0] d, input logic c,
                             input logic z, input logic e, input logic [1:0] rd);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_carry"}, res_carry, c);
        chk({tag, "_zero"}, res_zero, z);
        chk({tag, "_err"}, res_err, e);
        chk({tag, "_rd"}, res_rd, rd);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 12'd0;
        res_ready = 1'b0;
        dbg_sel = 2'd0;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_retired", retired_cnt, 0);
        chk("rst_dbg", dbg_data, 0);
        tick();

        // 1: LDI/LDI/ADD with carry out
        ldi(2'd0, 4'd9);
        ldi(2'd1, 4'd8);
        in_instr = mk(4'd3, 2'd2, 2'd0, 2'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_alu_a", alu_a, 9);
        chk("add_alu_b", alu_b, 8);
        chk("add_alu_op", alu_op, 3);
        tick();
        chk("add_valid", res_valid, 1);
        chk("resp_alu_op", alu_op, 0);
        check_res("add", 4'd1, 1'b1, 1'b0, 1'b0, 2'd2);
        release_resp();
        dbg_sel = 2'd2;
        #1;
        chk("add_dbg_r2", dbg_data, 1);
        chk("t1_retired", retired_cnt, 3);

        // 2: SUB with borrow, then self-subtract to zero
        ldi(2'd0, 4'd3);
        ldi(2'd1, 4'd5);
        issue(mk(4'd4, 2'd3, 2'd0, 2'd1));
        check_res("sub_borrow", 4'hE, 1'b1, 1'b0, 1'b0, 2'd3);
        release_resp();
        issue(mk(4'd4, 2'd3, 2'd1, 2'd1));
        check_res("sub_zero", 4'h0, 1'b0, 1'b1, 1'b0, 2'd3);
        release_resp();

        // 3: logic ops ignore alu_res[4]
        ldi(2'd0, 4'hA);
        ldi(2'd1, 4'hC);
        issue(mk(4'd6, 2'd2, 2'd0, 2'd1));
        check_res("nand", 4'h7, 1'b0, 1'b0, 1'b0, 2'd2);
        release_resp();
        issue(mk(4'd10, 2'd2, 2'd0, 2'd1));
        check_res("xnor", 4'h9, 1'b0, 1'b0, 1'b0, 2'd2);
        release_resp();
        chk("t3_retired", retired_cnt, 11);

        // 4: illegal opcode, no writeback, no retire
        issue(mk(4'd12, 2'd1, 2'd0, 2'd0));
        check_res("illegal", 4'h0, 1'b0, 1'b1, 1'b1, 2'd1);
        release_resp();
        dbg_sel = 2'd1;
        #1;
        chk("illegal_r1_kept", dbg_data, 4'hC);
        chk("illegal_retired", retired_cnt, 11);

        // 5: backpressure in RESP with a pending instruction waiting
        issue({4'd1, 2'd3, 2'b00, 4'd6});
        in_instr = {4'd1, 2'd2, 2'b00, 4'hF};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 6);
            chk("bp_rd", res_rd, 3);
            chk("bp_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_idle_valid", res_valid, 0);
        chk("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", in_ready, 0);
        tick();
        chk("bp_second_valid", res_valid, 1);
        check_res("bp_second", 4'hF, 1'b0, 1'b0, 1'b0, 2'd2);
        release_resp();
        chk("t5_retired", retired_cnt, 13);

        // 6a: reset during EXEC aborts the ADD
        ldi(2'd1, 4'd7);
        in_instr = mk(4'd3, 2'd1, 2'd0, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("abort_exec_op", alu_op, 3);
        rst = 1'b1;
        #1;
        dbg_sel = 2'd1;
        #1;
        chk("abort_alu_a", alu_a, 0);
        chk("abort_alu_b", alu_b, 0);
        chk("abort_alu_op", alu_op, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_data", res_data, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_retired", retired_cnt, 0);
        chk("abort_r1", dbg_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_result", res_valid, 0);
        end
        chk("abort_ready", in_ready, 1);
        chk("abort_r1_after", dbg_data, 0);

        // 6b: retired counter saturation
        for (int i = 0; i < 256; i++) begin
            ldi(2'd0, 4'(i));
            chk("sat_cnt", retired_cnt, (i < 255) ? 16'(i + 1) : 16'd255);
        end
        chk("sat_final", retired_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
